// File: rtl/regfile_mt_pkg.sv
// Shared types and sizes for the multi-threaded register file.
package regfile_mt_pkg;
  localparam int REGFILE_SIZE = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } rf_state_e;
endpackage

// File: rtl/regfile_mt_if.sv
// Decode/writeback/clear signal bundle of the multi-threaded register file.
interface regfile_mt_if #(
  parameter int DWIDTH         = 32,
  parameter int NUM_THREADS    = 4,
  parameter int NUM_READ_PORTS = 2
);
  localparam int TW = $clog2(NUM_THREADS);

  logic [TW-1:0]                          i_thread_index_decode;
  logic [NUM_READ_PORTS-1:0][4:0]         i_read_addr;
  logic [TW-1:0]                          i_thread_index_writeback;
  logic [4:0]                             i_write_addr;
  logic [DWIDTH-1:0]                      i_write_data;
  logic                                   i_wr_en;
  logic                                   i_clear_req;
  logic [TW-1:0]                          i_clear_thread;
  logic [NUM_READ_PORTS-1:0][DWIDTH-1:0]  o_read_data;
  logic                                   o_init_done;
  logic                                   o_clear_busy;
  logic                                   o_wr_collision;

  modport master (
    output i_thread_index_decode, i_read_addr, i_thread_index_writeback,
           i_write_addr, i_write_data, i_wr_en, i_clear_req, i_clear_thread,
    input  o_read_data, o_init_done, o_clear_busy, o_wr_collision
  );

  modport slave (
    input  i_thread_index_decode, i_read_addr, i_thread_index_writeback,
           i_write_addr, i_write_data, i_wr_en, i_clear_req, i_clear_thread,
    output o_read_data, o_init_done, o_clear_busy, o_wr_collision
  );
endinterface

// File: rtl/regfile_mt_bram.sv
// One register bank: simple dual-port RAM, registered read-first output.
module regfile_mt_bram #(
  parameter int DWIDTH      = 32,
  parameter int AW          = 7,
  parameter int ENABLE_BRAM = 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);
  generate
    if (ENABLE_BRAM != 0) begin : g_bram
      (* ram_style = "block" *) logic [DWIDTH-1:0] r_mem [2**AW];
      always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
      end
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [DWIDTH-1:0] r_mem [2**AW];
      logic [DWIDTH-1:0] w_rd;
      assign w_rd = r_mem[i_raddr];
      always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= w_rd;
      end
    end
  endgenerate
endmodule

// File: rtl/regfile_mt.sv
// Multi-threaded register file: per-port banks, sweep FSM (init/clear),
// write-to-read bypass and zero masking of x0 / uninitialised / clearing reads.
module regfile_mt
  import regfile_mt_pkg::*;
#(
  parameter int DWIDTH              = 32,
  parameter int NUM_THREADS         = 4,
  parameter int NUM_READ_PORTS      = 2,
  parameter int ENABLE_BRAM_REGFILE = 1,
  parameter int ENABLE_BYPASS       = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_mt_if.slave bus
);
  localparam int TW      = $clog2(NUM_THREADS);
  localparam int RF_SIZE = REGFILE_SIZE * NUM_THREADS;
  localparam int AW      = $clog2(RF_SIZE);
  localparam logic [AW-1:0] CNT_LAST = AW'(RF_SIZE - 1);

  rf_state_e         r_state, w_state_nxt;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_clr_thread, w_clr_thread_nxt;
  logic              r_init_done, r_clear_busy, r_wr_collision;
  logic              w_we, w_ext_we, w_ext_acc;
  logic [AW-1:0]     w_waddr, w_ext_addr;
  logic [DWIDTH-1:0] w_wdata;
  logic [DWIDTH-1:0] r_wdata_p1;
  logic [DWIDTH-1:0] w_rd_data [NUM_READ_PORTS];

  assign w_ext_we   = bus.i_wr_en && (bus.i_write_addr != 5'd0);
  assign w_ext_addr = {bus.i_thread_index_writeback, bus.i_write_addr};
  assign w_ext_acc  = (r_state == IDLE) && w_ext_we;

  // Sweep FSM and write-port mux: sweeps own the port and write zeros.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_clr_thread_nxt = r_clr_thread;
    w_we             = 1'b0;
    w_waddr          = w_ext_addr;
    w_wdata          = bus.i_write_data;
    case (r_state)
      INIT: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
        if (r_cnt == CNT_LAST) w_state_nxt = IDLE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      IDLE: begin
        w_we = w_ext_we;
        if (bus.i_clear_req) begin
          w_state_nxt      = CLEAR;
          w_cnt_nxt        = '0;
          w_clr_thread_nxt = bus.i_clear_thread;
        end
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = {r_clr_thread, r_cnt[4:0]};
        w_wdata = '0;
        if (r_cnt[4:0] == 5'd31) w_state_nxt = IDLE;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= INIT;
      r_cnt          <= '0;
      r_clr_thread   <= '0;
      r_init_done    <= 1'b0;
      r_clear_busy   <= 1'b0;
      r_wr_collision <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_clr_thread   <= w_clr_thread_nxt;
      r_init_done    <= (w_state_nxt != INIT);
      r_clear_busy   <= (w_state_nxt == CLEAR);
      r_wr_collision <= bus.i_wr_en && (r_state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    r_wdata_p1 <= bus.i_write_data;
  end

  // Read stage p0 -> p1: bank read plus registered bypass / zero-mask flags.
  generate
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      logic [AW-1:0]     w_raddr;
      logic [DWIDTH-1:0] w_ram_q;
      logic              w_zero, w_hit;
      logic              r_zero_p1, r_hit_p1;

      assign w_raddr = {bus.i_thread_index_decode, bus.i_read_addr[p]};
      assign w_zero  = (bus.i_read_addr[p] == 5'd0) || !r_init_done ||
                       ((r_state == CLEAR) && (bus.i_thread_index_decode == r_clr_thread));
      assign w_hit   = (ENABLE_BYPASS != 0) && w_ext_acc && (w_raddr == w_ext_addr);

      regfile_mt_bram #(
        .DWIDTH      (DWIDTH),
        .AW          (AW),
        .ENABLE_BRAM (ENABLE_BRAM_REGFILE)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_zero_p1 <= 1'b1;
          r_hit_p1  <= 1'b0;
        end else begin
          r_zero_p1 <= w_zero;
          r_hit_p1  <= w_hit;
        end
      end

      assign w_rd_data[p] = r_zero_p1 ? '0 : (r_hit_p1 ? r_wdata_p1 : w_ram_q);
    end
  endgenerate

  always_comb begin
    bus.o_read_data = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) bus.o_read_data[p] = w_rd_data[p];
  end

  assign bus.o_init_done    = r_init_done;
  assign bus.o_clear_busy   = r_clear_busy;
  assign bus.o_wr_collision = r_wr_collision;
endmodule

// File: tb/tb_regfile_mt.sv
// Bench for regfile_mt: vector table, randomized model comparison, sweep corner cases.
module tb_regfile_mt;
  localparam int DW = 32;
  localparam int NT = 4;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mt_if #(.DWIDTH(DW), .NUM_THREADS(NT), .NUM_READ_PORTS(NP)) bus ();

  regfile_mt #(
    .DWIDTH(DW), .NUM_THREADS(NT), .NUM_READ_PORTS(NP),
    .ENABLE_BRAM_REGFILE(1), .ENABLE_BYPASS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [NT][32];

  typedef struct {
    logic          we;
    int            wt;
    int            wr;
    logic [DW-1:0] wd;
    int            rt;
    int            r0;
    int            r1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input int wt, input int wr, input logic [DW-1:0] wd,
                       input int rt, input int r0, input int r1);
    bus.i_wr_en                    = we;
    bus.i_thread_index_writeback   = 2'(wt);
    bus.i_write_addr               = 5'(wr);
    bus.i_write_data               = wd;
    bus.i_thread_index_decode      = 2'(rt);
    bus.i_read_addr[0]             = 5'(r0);
    bus.i_read_addr[1]             = 5'(r1);
  endtask

  // Architectural view: x0 reads 0; a same-cycle accepted write to the same register is seen.
  function automatic logic [DW-1:0] model_read(input int t, input int r, input logic we,
                                               input int wt, input int wr, input logic [DW-1:0] wd);
    if (r == 0) return '0;
    if (we && wr != 0 && wt == t && wr == r) return wd;
    return mem[t][r];
  endfunction

  function automatic void model_write(input logic we, input int wt, input int wr, input logic [DW-1:0] wd);
    if (we && wr != 0) mem[wt][wr] = wd;
  endfunction

  task automatic wait_init(output int n);
    n = 0;
    while (!bus.o_init_done && n < 1000) begin
      drive(1'b0, 0, 0, '0, $urandom_range(0, NT-1), $urandom_range(0, 31), $urandom_range(0, 31));
      step();
      n++;
      if (n % 16 == 0) check("read_during_init", bus.o_read_data[0], '0);
    end
  endtask

  task automatic zero_model();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < 32; r++) mem[t][r] = '0;
  endtask

  initial begin
    int n, nb, k;
    logic we, prev_we;
    int wt, wr, rt, r0, r1;
    logic [DW-1:0] wd, e0, e1;

    zero_model();
    rst_n = 1'b0;
    bus.i_clear_req    = 1'b0;
    bus.i_clear_thread = '0;
    drive(1'b0, 0, 0, '0, 0, 0, 0);

    // Reset state
    repeat (3) step();
    check("rst_rd0", bus.o_read_data[0], '0);
    check("rst_rd1", bus.o_read_data[1], '0);
    check("rst_init_done", bus.o_init_done, 1'b0);
    check("rst_clear_busy", bus.o_clear_busy, 1'b0);
    check("rst_collision", bus.o_wr_collision, 1'b0);

    rst_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, 128);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 0, '0, i, 31 - i, i + 3);
      step();
      check("post_init_rd0", bus.o_read_data[0], '0);
      check("post_init_rd1", bus.o_read_data[1], '0);
    end

    // Directed vectors: write/read, x0 suppression, dual-port bypass
    vecs[0] = '{1'b1, 2, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 0, 0, 32'h0,        2, 5, 0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 2, 0, 32'h00001234, 2, 0, 0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 0, 0, 32'h0,        2, 0, 5, 32'h0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1, 7, 32'hA5A5A5A5, 1, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 1, 7, 32'h11111111, 1, 6, 7, 32'h0, 32'h11111111};
    vecs[6] = '{1'b0, 0, 0, 32'h0,        1, 7, 0, 32'h11111111, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].wt, vecs[i].wr, vecs[i].wd, vecs[i].rt, vecs[i].r0, vecs[i].r1);
      step();
      check($sformatf("vec%0d_rd0", i), bus.o_read_data[0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), bus.o_read_data[1], vecs[i].e1);
      model_write(vecs[i].we, vecs[i].wt, vecs[i].wr, vecs[i].wd);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      wt = $urandom_range(0, NT-1);
      wr = $urandom_range(0, 31);
      wd = $urandom;
      rt = $urandom_range(0, NT-1);
      r0 = $urandom_range(0, 31);
      r1 = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin rt = wt; r0 = wr; end
      if ($urandom_range(0, 3) == 0) begin rt = wt; r1 = wr; end
      e0 = model_read(rt, r0, we, wt, wr, wd);
      e1 = model_read(rt, r1, we, wt, wr, wd);
      drive(we, wt, wr, wd, rt, r0, r1);
      step();
      check("rand_rd0", bus.o_read_data[0], e0);
      check("rand_rd1", bus.o_read_data[1], e1);
      model_write(we, wt, wr, wd);
    end

    // Fill every thread with non-zero values
    for (int t = 0; t < NT; t++)
      for (int r = 1; r < 32; r++) begin
        wd = $urandom | 32'h1;
        drive(1'b1, t, r, wd, 0, 0, 0);
        step();
        model_write(1'b1, t, r, wd);
      end
    drive(1'b0, 0, 0, '0, 0, 0, 0);

    // Clear thread 3, with colliding writes and a re-request mid-sweep
    bus.i_clear_req    = 1'b1;
    bus.i_clear_thread = 2'd3;
    step();
    check("clear_busy_rise", bus.o_clear_busy, 1'b1);
    nb = 0;
    k  = 0;
    while (bus.o_clear_busy && k < 100) begin
      nb++;
      prev_we = (k < 5);
      bus.i_clear_req    = (k == 10);
      bus.i_clear_thread = 2'd0;
      drive(prev_we, 0, 1, 32'h00000BAD, 3, (k % 31) + 1, ((k + 9) % 31) + 1);
      step();
      k++;
      check("collision_pulse", bus.o_wr_collision, prev_we);
      check("clearing_rd0", bus.o_read_data[0], '0);
      check("clearing_rd1", bus.o_read_data[1], '0);
    end
    check("clear_busy_cycles", nb, 32);
    bus.i_clear_req = 1'b0;
    drive(1'b0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_extra_sweep", bus.o_clear_busy, 1'b0);
      check("collision_idle", bus.o_wr_collision, 1'b0);
    end
    for (int r = 0; r < 32; r++) mem[3][r] = '0;

    for (int t = 0; t < NT; t++)
      for (int r = 0; r < 32; r++) begin
        drive(1'b0, 0, 0, '0, t, r, 31 - r);
        step();
        check($sformatf("post_clear_t%0d_x%0d", t, r), bus.o_read_data[0], model_read(t, r, 1'b0, 0, 0, '0));
        check("post_clear_rd1", bus.o_read_data[1], model_read(t, 31 - r, 1'b0, 0, 0, '0));
      end

    // Reset in the middle of a clear sweep
    bus.i_clear_req    = 1'b1;
    bus.i_clear_thread = 2'd2;
    step();
    bus.i_clear_req = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("midrst_rd0", bus.o_read_data[0], '0);
    check("midrst_rd1", bus.o_read_data[1], '0);
    check("midrst_init_done", bus.o_init_done, 1'b0);
    check("midrst_clear_busy", bus.o_clear_busy, 1'b0);
    check("midrst_collision", bus.o_wr_collision, 1'b0);
    zero_model();
    repeat (2) step();
    rst_n = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, 128);
    for (int t = 0; t < NT; t++) begin
      drive(1'b0, 0, 0, '0, t, 5 + t, 31);
      step();
      check("reinit_rd0", bus.o_read_data[0], '0);
      check("reinit_rd1", bus.o_read_data[1], '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
